// File: rtl/pwm_pkg.sv
// Shared constants and FSM state type for the PWM capture block.
package pwm_pkg;
   localparam int DEF_CNT_W    = 16;
   localparam int PRESCALE_W   = 8;
   localparam int MAX_PRESCALE = 15;
   localparam int FILTER_LEN   = 3;

   typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} cap_state_e;
endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronizer, optional glitch filter (PWM_CAPTURE_FILTER_EN) and edge detect for pwm_in.
module pwm_edge_sync
   import pwm_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pwm_in,
   output logic rise_det,
   output logic fall_det
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   lvl, lvl_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
   end

`ifdef PWM_CAPTURE_FILTER_EN
   logic [FILTER_LEN-2:0] hist_q;
   logic                  filt_q;

   // Level follows the input only once it has been stable for FILTER_LEN samples.
   always_comb begin
      lvl = filt_q;
      if (&{hist_q, sync_q[SYNC_STAGES-1]})       lvl = 1'b1;
      else if (~|{hist_q, sync_q[SYNC_STAGES-1]}) lvl = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q <= '0;
         filt_q <= 1'b0;
      end else begin
         hist_q <= {hist_q[FILTER_LEN-3:0], sync_q[SYNC_STAGES-1]};
         filt_q <= lvl;
      end
   end

   assign lvl_q = filt_q;
`else
   assign lvl = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lvl_q <= 1'b0;
      else        lvl_q <= lvl;
   end
`endif

   assign rise_det = lvl & ~lvl_q;
   assign fall_det = ~lvl & lvl_q;
endmodule

// File: rtl/pwm_capture.sv
// PWM input capture: measures period and high time in prescaled ticks.
// Optional glitch filter on the input via PWM_CAPTURE_FILTER_EN.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pwm_in,
   input  logic                  en,
   input  logic                  capture_reset,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic [CNT_W-1:0]      period_val,
   output logic [CNT_W-1:0]      high_time,
   output logic                  cap_valid,
   output logic                  overflow,
   output logic                  busy
);
   cap_state_e              state, state_n;
   logic                    rise_det, fall_det;
   logic [3:0]              p_eff;
   logic [MAX_PRESCALE-1:0] pre_cnt, pre_mask;
   logic [CNT_W-1:0]        meas_cnt, hi_lat, elapsed;
   logic                    tick, active, sat, capture;

   pwm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
      .clk      (clk),
      .rst_n    (rst_n),
      .pwm_in   (pwm_in),
      .rise_det (rise_det),
      .fall_det (fall_det)
   );

   assign p_eff    = (prescale > PRESCALE_W'(MAX_PRESCALE)) ? 4'(MAX_PRESCALE) : prescale[3:0];
   // For p=15 the shift wraps to 0 and the subtract yields the all-ones mask.
   assign pre_mask = (MAX_PRESCALE'(1) << p_eff) - MAX_PRESCALE'(1);
   assign tick     = (pre_cnt == pre_mask);
   assign elapsed  = meas_cnt + CNT_W'(tick);
   assign active   = (state == HIGH) || (state == LOW);
   assign sat      = active && tick && (meas_cnt == {CNT_W{1'b1}});
   assign busy     = active;

   always_comb begin
      state_n = state;
      capture = 1'b0;
      if (capture_reset) state_n = en ? ARM : IDLE;
      else if (!en)      state_n = IDLE;
      else begin
         case (state)
            IDLE: state_n = ARM;
            ARM:  if (rise_det) state_n = HIGH;
            HIGH: if (sat) state_n = ARM;
                  else if (fall_det) state_n = LOW;
            LOW:  if (sat) state_n = ARM;
                  else if (rise_det) begin
                     state_n = HIGH;
                     capture = 1'b1;
                  end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_val <= '0;
         high_time  <= '0;
         cap_valid  <= 1'b0;
         overflow   <= 1'b0;
         meas_cnt   <= '0;
         pre_cnt    <= '0;
         hi_lat     <= '0;
      end else if (capture_reset) begin
         period_val <= '0;
         high_time  <= '0;
         cap_valid  <= 1'b0;
         overflow   <= 1'b0;
         meas_cnt   <= '0;
         pre_cnt    <= '0;
         hi_lat     <= '0;
      end else begin
         cap_valid <= capture;
         if (capture) begin
            period_val <= elapsed;
            high_time  <= hi_lat;
         end
         if (en && sat) overflow <= 1'b1;
         if (!en || state == IDLE || sat) begin
            meas_cnt <= '0;
            pre_cnt  <= '0;
            hi_lat   <= '0;
         end else if (rise_det) begin
            // Restart the tick phase on every rise so results floor cleanly.
            meas_cnt <= '0;
            pre_cnt  <= '0;
         end else if (active) begin
            pre_cnt  <= tick ? '0 : pre_cnt + MAX_PRESCALE'(1);
            meas_cnt <= elapsed;
            if (state == HIGH && fall_det) hi_lat <= elapsed;
         end
      end
   end
endmodule

// File: tb/tb_pwm_capture.sv
// Randomized bench for pwm_capture; expected captures come from a waveform-level model.
module tb_pwm_capture;
   logic        clk = 1'b0;
   logic        rst_n, pwm_in, en, capture_reset;
   logic [7:0]  prescale;
   logic [15:0] period_val, high_time;
   logic        cap_valid, overflow, busy;

   int n_chk = 0, n_pass = 0;
   int cyc_cnt = 0;

   // driven waveform, as (level, length in clk) segments since the DUT was last armed
   bit seg_l[$];
   int seg_n[$];
   // observed captures
   int q_per[$], q_hi[$], q_ts[$];
   // expected captures
   int e_per[$], e_hi[$], e_dt[$];

   pwm_capture dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pwm_in        (pwm_in),
      .en            (en),
      .capture_reset (capture_reset),
      .prescale      (prescale),
      .period_val    (period_val),
      .high_time     (high_time),
      .cap_valid     (cap_valid),
      .overflow      (overflow),
      .busy          (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   always @(negedge clk) begin
      if (rst_n && cap_valid) begin
         q_per.push_back(int'(period_val));
         q_hi.push_back(int'(high_time));
         q_ts.push_back(cyc_cnt);
      end
   end

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_all();
      seg_l.delete(); seg_n.delete();
      q_per.delete(); q_hi.delete(); q_ts.delete();
   endtask

   task automatic add(input bit l, input int n);
      seg_l.push_back(l);
      seg_n.push_back(n);
   endtask

   task automatic add_pwm(input int per, input int hi, input int n);
      repeat (n) begin
         add(1'b1, hi);
         add(1'b0, per - hi);
      end
      add(1'b1, 10);
   endtask

   task automatic play(input int from);
      for (int i = from; i < seg_l.size(); i++) begin
         pwm_in = seg_l[i];
         cyc(seg_n[i]);
      end
   endtask

   // Waveform-level model: every rise after the first reports rise-to-rise and
   // rise-to-fall intervals, floored to 2^p-clk ticks.
   task automatic build_exp(input int p);
      bit l[$];
      int n[$];
      int rises[$], falls[$];
      int t, f;
      bit prev, found;
      l = seg_l;
      n = seg_n;
      e_per.delete(); e_hi.delete(); e_dt.delete();
`ifdef PWM_CAPTURE_FILTER_EN
      begin
         int i;
         i = 1;
         while (i < l.size() - 1) begin
            if (n[i] < 3) begin
               n[i-1] += n[i] + n[i+1];
               l.delete(i+1); n.delete(i+1);
               l.delete(i);   n.delete(i);
            end else i++;
         end
      end
`endif
      t = 0;
      prev = 1'b0;
      for (int i = 0; i < l.size(); i++) begin
         if (l[i] && !prev) rises.push_back(t);
         if (!l[i] && prev) falls.push_back(t);
         prev = l[i];
         t += n[i];
      end
      for (int i = 1; i < rises.size(); i++) begin
         f = rises[i-1];
         found = 1'b0;
         foreach (falls[j])
            if (!found && falls[j] > rises[i-1] && falls[j] < rises[i]) begin
               f = falls[j];
               found = 1'b1;
            end
         e_per.push_back((rises[i] - rises[i-1]) >> p);
         e_hi.push_back((f - rises[i-1]) >> p);
         e_dt.push_back(rises[i] - rises[i-1]);
      end
   endtask

   task automatic compare(input string tag);
      int k;
      build_exp(int'(prescale));
      chk({tag, "_ncap"}, q_per.size(), e_per.size());
      k = (q_per.size() < e_per.size()) ? q_per.size() : e_per.size();
      for (int i = 0; i < k; i++) begin
         chk($sformatf("%s_per%0d", tag, i), q_per[i], e_per[i]);
         chk($sformatf("%s_hi%0d", tag, i), q_hi[i], e_hi[i]);
         if (i > 0) chk($sformatf("%s_dt%0d", tag, i), q_ts[i] - q_ts[i-1], e_dt[i]);
      end
   endtask

   task automatic end_cfg();
      pwm_in = 1'b0;
      cyc(10);
      capture_reset = 1'b1;
      cyc(1);
      capture_reset = 1'b0;
      cyc(2);
      clear_all();
   endtask

   task automatic run_cfg(input string tag, input int p, input int per, input int hi, input int n);
      prescale = 8'(p);
      clear_all();
      add_pwm(per, hi, n);
      play(0);
      compare(tag);
      end_cfg();
   endtask

   int glitch_exp;

   initial begin
      rst_n = 1'b0; pwm_in = 1'b0; en = 1'b0; capture_reset = 1'b0; prescale = 8'd0;
      cyc(3);
      rst_n = 1'b1;
      cyc(2);
      chk("rst_per", period_val, 0);
      chk("rst_hi", high_time, 0);
      chk("rst_vld", cap_valid, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_busy", busy, 0);
      en = 1'b1;
      cyc(2);

      // directed 100/30 at prescale 0, then 100/40 at prescale 2
      prescale = 8'd0;
      clear_all();
      add_pwm(100, 30, 4);
      play(0);
      compare("p0");
      if (q_per.size() > 0) begin
         chk("p0_per_abs", q_per[0], 100);
         chk("p0_hi_abs", q_hi[0], 30);
      end
      end_cfg();

      prescale = 8'd2;
      clear_all();
      add_pwm(100, 40, 3);
      play(0);
      compare("p2");
      if (q_per.size() > 0) begin
         chk("p2_per_abs", q_per[0], 25);
         chk("p2_hi_abs", q_hi[0], 10);
      end
      end_cfg();

      for (int r = 0; r < 5; r++) begin
         int p, per, hi;
         p   = $urandom_range(0, 3);
         per = $urandom_range(24, 200);
         hi  = $urandom_range(6, per - 6);
         run_cfg($sformatf("rnd%0d", r), p, per, hi, 3);
      end

      // input stuck low after one rise: saturate, no capture, back to ARM
      prescale = 8'd0;
      clear_all();
      add(1'b1, 20);
      add(1'b0, 65600);
      play(0);
      chk("sat_ovf", overflow, 1);
      chk("sat_busy", busy, 0);
      chk("sat_ncap", q_per.size(), 0);
      clear_all();
      add_pwm(100, 30, 3);
      play(0);
      compare("resume");
      chk("resume_ovf", overflow, 1);
      capture_reset = 1'b1;
      cyc(1);
      capture_reset = 1'b0;
      chk("crst_ovf", overflow, 0);
      end_cfg();

      // capture_reset while HIGH
      clear_all();
      add_pwm(100, 30, 2);
      play(0);
      compare("pre_crst");
      chk("high_busy", busy, 1);
      capture_reset = 1'b1;
      cyc(1);
      capture_reset = 1'b0;
      chk("crst_per", period_val, 0);
      chk("crst_hi", high_time, 0);
      chk("crst_ovf2", overflow, 0);
      chk("crst_busy", busy, 0);
      pwm_in = 1'b0;
      cyc(20);
      clear_all();
      add_pwm(100, 30, 1);
      play(0);
      compare("post_crst");
      end_cfg();

      // en dropped during LOW
      clear_all();
      add_pwm(100, 30, 2);
      play(0);
      compare("pre_en");
      cyc(20);
      pwm_in = 1'b0;
      cyc(20);
      en = 1'b0;
      cyc(10);
      chk("en_busy", busy, 0);
      chk("en_hold_per", period_val, 100);
      chk("en_hold_hi", high_time, 30);
      en = 1'b1;
      cyc(40);
      chk("en_nocap", q_per.size(), 2);
      clear_all();
      add_pwm(100, 30, 2);
      play(0);
      compare("post_en");
      end_cfg();

      // 2-clk low glitch inside the high phase
`ifdef PWM_CAPTURE_FILTER_EN
      glitch_exp = 100;
`else
      glitch_exp = 12;
`endif
      clear_all();
      repeat (3) begin
         add(1'b1, 10); add(1'b0, 2); add(1'b1, 18); add(1'b0, 70);
      end
      add(1'b1, 10);
      play(0);
      compare("glitch");
      if (q_per.size() > 0) chk("glitch_per_abs", q_per[0], glitch_exp);
      end_cfg();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
